// File: rtl/lm_iq_pkg.sv
// Shared sizing and types for the instruction-queue controller.
// DW: instruction word width (matches RAM width); DEPTH: RAM entries;
// AW: RAM address width; LW: level width (holds DEPTH + 2).
package lm_iq_pkg;

  localparam int unsigned DW    = 512;
  localparam int unsigned DEPTH = 512;
  localparam int unsigned AW    = 9;
  localparam int unsigned LW    = 10;

  typedef logic [DW-1:0] iq_word_t;

endpackage : lm_iq_pkg

// File: rtl/lm_iq_obuf.sv
// Two-entry registered output FIFO that absorbs the RAM read latency.
// Ports: clk/rst_n clock and async active-low reset; clr synchronous clear;
// wr/wdata tail write; pop head consume; valid/head registered head view;
// cnt current occupancy; cnt_nxt_c next-cycle occupancy (combinational).
module lm_iq_obuf
  import lm_iq_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       wr,
  input  iq_word_t   wdata,
  input  logic       pop,
  output logic       valid,
  output iq_word_t   head,
  output logic [1:0] cnt,
  output logic [1:0] cnt_nxt_c
);

  iq_word_t tail;
  iq_word_t head_nxt;
  iq_word_t tail_nxt;

  // Next-state: the read-issue throttle guarantees wr never lands on a full
  // buffer, and pop only occurs with cnt != 0.
  always_comb begin
    head_nxt  = head;
    tail_nxt  = tail;
    cnt_nxt_c = cnt;
    if (clr) begin
      cnt_nxt_c = 2'd0;
    end else begin
      case ({wr, pop})
        2'b10: begin
          if (cnt == 2'd0) head_nxt = wdata;
          else             tail_nxt = wdata;
          cnt_nxt_c = cnt + 2'd1;
        end
        2'b01: begin
          head_nxt  = tail;
          cnt_nxt_c = cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            head_nxt = wdata;
          end else begin
            head_nxt = tail;
            tail_nxt = wdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Buffer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      cnt   <= 2'd0;
      valid <= 1'b0;
    end else begin
      head  <= head_nxt;
      tail  <= tail_nxt;
      cnt   <= cnt_nxt_c;
      valid <= (cnt_nxt_c != 2'd0);
    end
  end

endmodule : lm_iq_obuf

// File: rtl/lm_iq_ctrl.sv
// Instruction-queue controller: turns a 1-cycle-latency two-port RAM into a
// zero-bubble valid/ready FIFO.
// Ports: CLK/RSTN clock and async active-low reset; flush synchronous clear;
// in_valid/in_ready/in_data push side; out_valid/out_ready/out_data pop side;
// level registered word count; mem_cena/mem_aa/mem_qa RAM read port;
// mem_cenb/mem_ab/mem_db RAM write port (enables active low).
module lm_iq_ctrl
  import lm_iq_pkg::*;
(
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  iq_word_t      in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output iq_word_t      out_data,
  output logic [LW-1:0] level,
  output logic          mem_cena,
  output logic [AW-1:0] mem_aa,
  input  iq_word_t      mem_qa,
  output logic          mem_cenb,
  output logic [AW-1:0] mem_ab,
  output iq_word_t      mem_db
);

  localparam int unsigned CW = AW + 1;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] ram_cnt;
  logic [CW-1:0] ram_cnt_nxt;
  logic          inflight;
  logic          alive;
  logic [1:0]    ob_cnt;
  logic [1:0]    ob_cnt_nxt;
  logic [2:0]    occ;
  logic          push;
  logic          pop;
  logic          rd_go;
  logic          ret;

  // alive holds in_ready low while in reset and releases it on the first edge after.
  assign in_ready = alive & (ram_cnt != CW'(DEPTH)) & ~flush;
  assign push     = in_valid & in_ready;
  assign pop      = out_valid & out_ready;

  // Issue a read only if its data is guaranteed a buffer slot on return.
  assign occ   = 3'(ob_cnt) + 3'(inflight);
  assign rd_go = (ram_cnt != '0) & (occ < (3'd2 + 3'(pop))) & ~flush;
  assign ret   = inflight & ~flush;

  // RAM port drive; write and read addresses never coincide since a word is
  // readable only once counted in ram_cnt.
  assign mem_cenb = ~push;
  assign mem_ab   = wr_ptr;
  assign mem_db   = push ? in_data : '0;
  assign mem_cena = ~rd_go;
  assign mem_aa   = rd_ptr;

  // RAM occupancy next state.
  always_comb begin
    ram_cnt_nxt = ram_cnt;
    if (push && !rd_go)      ram_cnt_nxt = ram_cnt + CW'(1);
    else if (!push && rd_go) ram_cnt_nxt = ram_cnt - CW'(1);
    if (flush)               ram_cnt_nxt = '0;
  end

  // Pointers, counters and the registered level.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ram_cnt  <= '0;
      inflight <= 1'b0;
      alive    <= 1'b0;
      level    <= '0;
    end else begin
      alive   <= 1'b1;
      ram_cnt <= ram_cnt_nxt;
      level   <= LW'(ram_cnt_nxt) + LW'(rd_go) + LW'(ob_cnt_nxt);
      if (flush) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        inflight <= 1'b0;
      end else begin
        if (push)  wr_ptr <= wr_ptr + AW'(1);
        if (rd_go) rd_ptr <= rd_ptr + AW'(1);
        inflight <= rd_go;
      end
    end
  end

  lm_iq_obuf u_obuf (
    .clk       (CLK),
    .rst_n     (RSTN),
    .clr       (flush),
    .wr        (ret),
    .wdata     (mem_qa),
    .pop       (pop),
    .valid     (out_valid),
    .head      (out_data),
    .cnt       (ob_cnt),
    .cnt_nxt_c (ob_cnt_nxt)
  );

endmodule : lm_iq_ctrl
